// File: rtl/cpu_wb_arbiter_pkg.sv
// Shared constants and types for the register-file write-back arbiter.
// Ports: none (package only).
package cpu_wb_arbiter_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int XLEN       = 32;

   localparam logic [REG_ADDR_W-1:0] X0_ADDR = '0;

   // One register-file write as held in the write stage.
   typedef struct packed {
      logic                  en;
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_write_t;

   // Writes to x0 are architecturally discarded.
   function automatic logic is_x0(input logic [REG_ADDR_W-1:0] a);
      return a == X0_ADDR;
   endfunction

endpackage

// File: rtl/cpu_rr_arbiter.sv
// Generic round-robin grant: first set request at or after i_ptr, wrapping.
// Ports: i_req (request vector), i_ptr (search start), o_grant (one-hot), o_idx, o_valid.
module cpu_rr_arbiter #(
   parameter int N     = 3,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [N-1:0]     o_grant,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_valid
);

   // Scan from the farthest slot back to i_ptr so the nearest request
   // is the last one written and therefore wins.
   always_comb begin
      o_idx   = '0;
      o_valid = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (i_req[(int'(i_ptr) + k) % N]) begin
            o_idx   = IDX_W'((int'(i_ptr) + k) % N);
            o_valid = 1'b1;
         end
      end
   end

   assign o_grant = o_valid ? (N'(1) << o_idx) : '0;

endmodule

// File: rtl/cpu_wb_arbiter.sv
// Round-robin write-back arbiter in front of the register file write port.
// Ports: req_* (valid/ready requesters), wr_en/rd/data_rd (registered write),
//        chk_rs1/chk_rs2 -> hz1/hz2 (pending-write hazards), stall_cnt.
module cpu_wb_arbiter
   import cpu_wb_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int CNT_W   = 16
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_REQ-1:0]              req_valid,
   output logic [NUM_REQ-1:0]              req_ready,
   input  logic [REG_ADDR_W*NUM_REQ-1:0]   req_rd,
   input  logic [XLEN*NUM_REQ-1:0]         req_data,
   output logic                            wr_en,
   output logic [REG_ADDR_W-1:0]           rd,
   output logic [XLEN-1:0]                 data_rd,
   input  logic [REG_ADDR_W-1:0]           chk_rs1,
   input  logic [REG_ADDR_W-1:0]           chk_rs2,
   output logic                            hz1,
   output logic                            hz2,
   output logic [CNT_W-1:0]                stall_cnt
);

   localparam int IDX_W = $clog2(NUM_REQ);

   logic [IDX_W-1:0]      r_ptr;
   wb_write_t             r_wb;
   logic [CNT_W-1:0]      r_cnt;

   logic [NUM_REQ-1:0]    w_grant;
   logic [IDX_W-1:0]      w_idx;
   logic                  w_gnt;
   logic [REG_ADDR_W-1:0] w_sel_rd;
   logic [XLEN-1:0]       w_sel_data;
   logic                  w_contend;
   logic                  w_hit1;
   logic                  w_hit2;

   cpu_rr_arbiter #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_rr (
      .i_req   (req_valid),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_valid (w_gnt)
   );

   // No handshake may complete while reset is held.
   assign req_ready = rst_n ? w_grant : '0;

   assign w_sel_rd   = req_rd[int'(w_idx)*REG_ADDR_W +: REG_ADDR_W];
   assign w_sel_data = req_data[int'(w_idx)*XLEN +: XLEN];

   // Two or more valid requesters means at least one is left waiting.
   assign w_contend = $countones(req_valid) >= 2;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ptr <= '0;
         r_wb  <= '0;
         r_cnt <= '0;
      end else begin
         // An x0 result is consumed but never written.
         r_wb.en <= w_gnt && !is_x0(w_sel_rd);
         if (w_gnt) begin
            r_wb.rd   <= w_sel_rd;
            r_wb.data <= w_sel_data;
            r_ptr     <= (w_idx == IDX_W'(NUM_REQ - 1)) ?
                         '0 : w_idx + IDX_W'(1);
         end
         if (w_contend && !(&r_cnt)) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   // A source is hazardous while any producer still holds a result for it
   // or the write stage is committing it this cycle.
   always_comb begin
      w_hit1 = 1'b0;
      w_hit2 = 1'b0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (req_valid[j] &&
             req_rd[j*REG_ADDR_W +: REG_ADDR_W] == chk_rs1) begin
            w_hit1 = 1'b1;
         end
         if (req_valid[j] &&
             req_rd[j*REG_ADDR_W +: REG_ADDR_W] == chk_rs2) begin
            w_hit2 = 1'b1;
         end
      end
   end

   assign hz1 = !is_x0(chk_rs1) &&
                (w_hit1 || (r_wb.en && r_wb.rd == chk_rs1));
   assign hz2 = !is_x0(chk_rs2) &&
                (w_hit2 || (r_wb.en && r_wb.rd == chk_rs2));

   assign wr_en     = r_wb.en;
   assign rd        = r_wb.rd;
   assign data_rd   = r_wb.data;
   assign stall_cnt = r_cnt;

endmodule
